// File: rtl/sumador_serial.sv
// sumador_serial: WIDTH-bit add/subtract/clear/hold unit that walks the
// operands SLICE bits per enabled clock, with a START/BUSY/DONE handshake.
//
// Ports
//   CLK, RST_N    clock, asynchronous active-low reset
//   ENB           global enable; 0 freezes every register (stall)
//   START         request, sampled only in IDLE with ENB=1
//   MODO          00 hold, 01 add, 10 subtract, 11 clear
//   A, B, Cin     operands and carry/borrow in, captured at the START edge
//   ACC           1 = operand A is the current Q
//   Q, RCO, OVF   registered result, carry/borrow out, signed overflow
//   BUSY, DONE    operation in flight / one-cycle result-updated pulse
module sumador_serial #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ENB,
  input  logic             START,
  input  logic [1:0]       MODO,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             ACC,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             OVF,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;      // operand A, shifted down one slice per step
  logic [WIDTH-1:0] b_q, b_d;      // effective operand B (already inverted for subtract)
  logic [WIDTH-1:0] res_q, res_d;  // shadow result, filled from the top
  logic             carry_q, carry_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             rco_q, rco_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [SLICE:0]   slice_sum;
  logic             msb_cin;

  // State and datapath registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sub_q   <= 1'b0;
      q_q     <= '0;
      rco_q   <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      sub_q   <= sub_d;
      q_q     <= q_d;
      rco_q   <= rco_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // Next-state, slice adder and result update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    sub_d   = sub_q;
    q_d     = q_q;
    rco_d   = rco_q;
    ovf_d   = ovf_q;
    done_d  = done_q;

    // Low slice of the shifted operands is always the one being processed
    slice_sum = {1'b0, a_q[SLICE-1:0]} + {1'b0, b_q[SLICE-1:0]} + (SLICE+1)'(carry_q);
    // Carry into the slice MSB; on the last slice this is the carry into bit WIDTH-1
    msb_cin   = a_q[SLICE-1] ^ b_q[SLICE-1] ^ slice_sum[SLICE-1];

    if (ENB) begin
      done_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (START) begin
            case (MODO)
              2'b00: done_d = 1'b1;
              2'b11: begin
                q_d    = '0;
                rco_d  = 1'b0;
                ovf_d  = 1'b0;
                done_d = 1'b1;
              end
              default: begin
                a_d     = ACC ? q_q : A;
                b_d     = MODO[1] ? ~B : B;
                carry_d = MODO[1] ? ~Cin : Cin;
                sub_d   = MODO[1];
                cnt_d   = '0;
                state_d = S_BUSY;
              end
            endcase
          end
        end
        S_BUSY: begin
          a_d     = a_q >> SLICE;
          b_d     = b_q >> SLICE;
          res_d   = (res_q >> SLICE) | (WIDTH'(slice_sum[SLICE-1:0]) << (WIDTH - SLICE));
          carry_d = slice_sum[SLICE];
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(NSLICE - 1)) begin
            // Atomic commit of the whole result on the last slice
            q_d     = res_d;
            rco_d   = slice_sum[SLICE] ^ sub_q;
            ovf_d   = msb_cin ^ slice_sum[SLICE];
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign Q    = q_q;
  assign RCO  = rco_q;
  assign OVF  = ovf_q;
  assign BUSY = (state_q == S_BUSY);
  assign DONE = done_q;

endmodule

// File: doc/sumador_serial.md
# sumador_serial

Parametrised, slice-serial successor of the team's 4-bit registered adder/subtractor. It performs WIDTH-bit add, subtract, clear or hold operations on a narrow SLICE-bit datapath, processing one slice per enabled clock. It uses a START/BUSY/DONE handshake, carry/borrow and signed-overflow flags, and an accumulate option that uses the last result as operand A. It sits in the datapath wherever a wide add/sub is needed and a single-cycle WIDTH-bit carry chain is too costly.

## Interface
- WIDTH, 16: operand/result width; must be a multiple of SLICE.
- SLICE, 4: bits processed per enabled cycle; NSLICE = WIDTH/SLICE (NSLICE = 1 is legal).
- CLK  in  1  clock; all state changes on its rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- ENB  in  1  enable; when 0, all registers and the FSM hold (stall).
- START  in  1  request; sampled only in IDLE with ENB=1.
- MODO  in  2  00 hold, 01 add, 10 subtract, 11 clear.
- A, B  in  WIDTH  operands, captured at the START edge.
- Cin  in  1  carry-in (add) / borrow-in (subtract).
- ACC  in  1  1 = use current Q as operand A instead of the A port.
- Q  out  WIDTH  registered result.
- RCO  out  1  carry-out (add) / borrow-out (subtract).
- OVF  out  1  signed two's-complement overflow.
- BUSY  out  1  high while in the BUSY state.
- DONE  out  1  one-cycle pulse when Q/RCO/OVF are updated.

## Operation
- The FSM has two states, IDLE and BUSY.
- Reset: state IDLE; Q=0, RCO=0, OVF=0, BUSY=0, DONE=0; slice counter, shadow registers and carry are cleared.
- IDLE, START=1, ENB=1: the block captures MODO, Cin and B. It captures operand A as Q when ACC=1, otherwise the A port.
- MODO 00 from IDLE: Q/RCO/OVF are unchanged; DONE=1 for the next cycle; state stays IDLE.
- MODO 11 from IDLE: Q=0, RCO=0, OVF=0 at the START edge; DONE=1 for the next cycle; state stays IDLE.
- MODO 01/10 from IDLE: go to BUSY with slice counter 0.
- Effective operation is A + B' + c0:
  - add: B' = B, c0 = Cin.
  - subtract: B' = ~B, c0 = ~Cin, giving A - B - Cin mod 2^WIDTH.
- Each enabled BUSY cycle processes slice i (bits i*SLICE+SLICE-1 : i*SLICE):
  - Slice sum goes to a shadow result register.
  - Carry out of the slice is stored for slice i+1.
  - The counter increments.
- Q is not modified until the final slice completes; the update is atomic.
- At the last slice (i = NSLICE-1), the following all update on the same edge:
  - Q is loaded from the shadow result.
  - RCO = final carry for add, or ~final carry (borrow) for subtract.
  - OVF = carry into MSB XOR carry out of MSB of the effective addition.
  - DONE=1 for the next cycle; state returns to IDLE.
- START while BUSY is ignored; operands are not re-captured.
- ENB=0 in any state freezes everything, including a pending DONE pulse (DONE stays asserted while stalled). START is not sampled while ENB=0.
- RST_N low mid-operation aborts immediately: all outputs return to reset values and the partial result is discarded.

## Timing
- START accepted at edge k: BUSY=1 after edge k.
- Last slice processed at edge k+NSLICE (with no stalls):
  - Q/RCO/OVF valid after edge k+NSLICE.
  - DONE=1 and BUSY=0 during that following cycle.
- Result latency is NSLICE enabled cycles; each cycle with ENB=0 adds one cycle.
- Hold/clear latency is 1 edge; DONE is high in the cycle after the START edge.
- A new START is sampled no earlier than edge k+NSLICE+1, i.e. in the DONE cycle. Maximum throughput is one operation per NSLICE+1 cycles.
- BUSY and DONE are never high in the same cycle.
- Asynchronous reset assertion is effective without a clock edge. Deassertion is synchronous to CLK by the system; the first accepted START comes at the first enabled edge after deassertion.

## Test plan
- Reset: assert RST_N=0 mid-BUSY with Q=0x1234 → Q=0x0000, RCO=OVF=BUSY=DONE=0 immediately; the next START behaves normally.
- Add with carry (WIDTH=16, SLICE=4): A=0xFFFF, B=0x0001, Cin=0, MODO=01 → BUSY 4 cycles; after edge k+4, Q=0x0000, RCO=1, OVF=0, DONE pulse of exactly 1 cycle.
- Subtract with borrow: A=0x0003, B=0x0005, Cin=1, MODO=10 → Q=0xFFFD, RCO=1, OVF=0.
- Signed overflow: A=0x7FFF, B=0x0001 add → Q=0x8000, OVF=1, RCO=0. A=0x8000, B=0x0001 subtract → Q=0x7FFF, OVF=1, RCO=0.
- Stall and ignored START: during an add, drop ENB for 2 cycles at slice 1 and pulse START while BUSY → DONE arrives at edge k+6; Q stays at its old value until then; result is correct; the second START has no effect.
- Accumulate and clear: Q=0x0010; ACC=1, B=0x0005, add → Q=0x0015. Then MODO=11 → Q=0, RCO=0, OVF=0, with DONE one cycle after START. Repeat the add with NSLICE=1 (SLICE=16) → DONE one cycle after START.
